tinker_prog_loader: RTL and testbench
=====================================

TINKER_PROG_LOADER -- requirements
Module: tinker_prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 64'h2000, is the byte address of the first program word.
REQ-002 Parameter MAX_WORDS, default 32'd129024, is the largest word count accepted; (524288-8192)/4.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_valid  in  1  in_byte holds a valid stream byte.
REQ-006 in_byte  in  8  stream byte.
REQ-007 in_ready  out  1  loader accepts a byte this cycle; a byte transfers when in_valid && in_ready.
REQ-008 mem_wr_en  out  1  one-cycle word write strobe to instruction memory.
REQ-009 mem_wr_addr  out  64  byte address of the written word.
REQ-010 mem_wr_data  out  32  word data, little-endian: first byte received sits in [7:0].
REQ-011 core_rst  out  1  hold-reset to tinker_core; high until the load completes.
REQ-012 done  out  1  load completed with a good checksum.
REQ-013 err  out  1  load failed.
REQ-014 words_loaded  out  32  count of words written so far.

Function
REQ-015 States: HDR, DATA, CSUM, DONE, ERR.
REQ-016 HDR accepts 4 bytes forming the 32-bit little-endian word count N.
- N==0 -> CSUM.
- N>MAX_WORDS -> ERR.
- Otherwise -> DATA.
REQ-017 DATA accepts 4*N bytes; each group of 4 assembles one word, first byte in [7:0].
REQ-018 Accepting the 4th byte of word k asserts, in the next cycle:
- mem_wr_en=1 for exactly one cycle;
- mem_wr_addr=BASE_ADDR+4*k;
- mem_wr_data=assembled word;
- words_loaded=k+1.
REQ-019 Accepting the last data byte moves to CSUM in the same edge; the final write strobe overlaps the first CSUM cycle.
REQ-020 Running checksum is the 8-bit XOR of all DATA bytes; header bytes are excluded; checksum is 8'h00 when N==0.
REQ-021 CSUM accepts one byte: equal to the checksum -> DONE, otherwise -> ERR.
REQ-022 in_ready=1 in HDR, DATA and CSUM; in_ready=0 in DONE and ERR.
REQ-023 Bytes presented while in_ready=0 are ignored; in_valid=0 cycles stall all state with no timeout.
REQ-024 DONE asserts done=1 and core_rst=0; both take effect in the cycle after the checksum byte is accepted.
REQ-025 ERR asserts err=1 and holds core_rst=1.
REQ-026 DONE and ERR are absorbing; only rst leaves them.
REQ-027 done and err are never both 1.
REQ-028 Word index and address arithmetic are unsigned; BASE_ADDR+4*k never wraps for k<MAX_WORDS.

Reset
REQ-029 While rst=1 on a clock edge, the loader enters HDR and holds these values the following cycle:
- in_ready=0 during that reset cycle;
- mem_wr_en=0, core_rst=1, done=0, err=0, words_loaded=0;
- checksum, byte counter and word index cleared.
REQ-030 rst mid-load aborts the load; any partial word is discarded with no write strobe; memory already written is left untouched.
REQ-031 rst taking effect in the same edge as a 4th data byte suppresses that word's write strobe.
REQ-032 The first cycle after rst deasserts has in_ready=1 in HDR.

Verification
REQ-033 N=1 load:
- Stream 01 00 00 00, 78 56 34 12, 08.
- Expect one strobe: addr 64'h2000, data 32'h12345678.
- Next cycle: done=1, core_rst=0, words_loaded=1.
REQ-034 Same stream with checksum byte 09 -> err=1, done=0, core_rst=1, in_ready=0.
REQ-035 Stream 00 00 00 00, 00 -> no write strobe, done=1, words_loaded=0.
REQ-036 Header 01 F8 01 00 (N=129025) -> err=1 right after the 4th header byte; no write strobes.
REQ-037 N=2 load:
- Stream 02 00 00 00, then 8 data bytes with random in_valid gaps.
- Expect strobes at 64'h2000 and 64'h2004, each exactly one cycle wide.
- words_loaded steps 1 then 2.
REQ-038 rst after 6 data bytes of an N=2 load:
- Only the 64'h2000 strobe occurs before reset.
- After reset: in_ready=1, words_loaded=0, core_rst=1.
- A fresh full load then completes normally.

Source files
------------

// File: rtl/tinker_prog_loader.sv
// Streams a length-prefixed program image into instruction memory, one 32-bit word per
// four bytes, then checks an XOR checksum before releasing the core from reset.
module tinker_prog_loader #(
  parameter logic [63:0] BASE_ADDR = 64'h2000,
  parameter logic [31:0] MAX_WORDS = 32'd129024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  output logic        mem_wr_en,
  output logic [63:0] mem_wr_addr,
  output logic [31:0] mem_wr_data,
  output logic        core_rst,
  output logic        done,
  output logic        err,
  output logic [31:0] words_loaded
);

  typedef enum logic [2:0] {
    S_HDR  = 3'd0,
    S_DATA = 3'd1,
    S_CSUM = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] n_q, n_d;
  logic [31:0] word_idx_q, word_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic        wr_en_q, wr_en_d;
  logic [63:0] wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic [31:0] words_loaded_q, words_loaded_d;

  logic        accept;
  logic [31:0] assembled;
  logic [31:0] word_idx_inc;

  // Ready drops combinationally while rst is held so no byte is consumed during reset.
  assign in_ready     = ((state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CSUM)) && !rst;
  assign accept       = in_valid && in_ready;
  assign assembled    = {in_byte, shift_q[31:8]};
  assign word_idx_inc = word_idx_q + 32'd1;

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    shift_d        = shift_q;
    n_d            = n_q;
    word_idx_d     = word_idx_q;
    csum_d         = csum_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    words_loaded_d = words_loaded_q;

    case (state_q)
      S_HDR: begin
        if (accept) begin
          shift_d    = assembled;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            n_d = assembled;
            if (assembled == 32'd0) begin
              state_d = S_CSUM;
            end else if (assembled > MAX_WORDS) begin
              state_d = S_ERR;
            end else begin
              state_d = S_DATA;
            end
          end
        end
      end

      S_DATA: begin
        if (accept) begin
          shift_d    = assembled;
          byte_cnt_d = byte_cnt_q + 2'd1;
          csum_d     = csum_q ^ in_byte;
          if (byte_cnt_q == 2'd3) begin
            wr_en_d        = 1'b1;
            wr_addr_d      = BASE_ADDR + {30'd0, word_idx_q, 2'b00};
            wr_data_d      = assembled;
            words_loaded_d = word_idx_inc;
            word_idx_d     = word_idx_inc;
            if (word_idx_inc == n_q) begin
              state_d = S_CSUM;
            end
          end
        end
      end

      S_CSUM: begin
        if (accept) begin
          state_d = (in_byte == csum_q) ? S_DONE : S_ERR;
        end
      end

      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
  end

  // Reset clears the strobe register, so a word completing on the reset edge is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_HDR;
      byte_cnt_q     <= 2'd0;
      shift_q        <= 32'd0;
      n_q            <= 32'd0;
      word_idx_q     <= 32'd0;
      csum_q         <= 8'd0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= 64'd0;
      wr_data_q      <= 32'd0;
      words_loaded_q <= 32'd0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      shift_q        <= shift_d;
      n_q            <= n_d;
      word_idx_q     <= word_idx_d;
      csum_q         <= csum_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      words_loaded_q <= words_loaded_d;
    end
  end

  assign mem_wr_en    = wr_en_q;
  assign mem_wr_addr  = wr_addr_q;
  assign mem_wr_data  = wr_data_q;
  assign words_loaded = words_loaded_q;
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign core_rst     = (state_q != S_DONE);

endmodule

// File: tb/tb_tinker_prog_loader.sv
// Randomized scoreboard bench for tinker_prog_loader: expected writes are queued from a
// byte-level reference model and a negedge monitor checks every write strobe against them.
module tb_tinker_prog_loader;

  localparam logic [63:0] BASE = 64'h2000;
  localparam logic [31:0] MAXW = 32'd129024;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        mem_wr_en;
  logic [63:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        core_rst;
  logic        done;
  logic        err;
  logic [31:0] words_loaded;

  typedef struct packed {
    logic [63:0] addr;
    logic [31:0] data;
    logic [31:0] cnt;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;
  bit  prev_wr = 1'b0;

  tinker_prog_loader dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_byte      (in_byte),
    .in_ready     (in_ready),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .core_rst     (core_rst),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every strobe must match the head of the expected-write queue.
  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      total++;
      if (prev_wr) begin
        bad++;
        $display("FAIL strobe_width: strobe high two cycles in a row at %0t", $time);
      end
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write: addr=%0h data=%0h at %0t", mem_wr_addr, mem_wr_data, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_wr_addr !== e.addr || mem_wr_data !== e.data || words_loaded !== e.cnt) begin
          bad++;
          $display("FAIL write: got addr=%0h data=%0h cnt=%0d expected addr=%0h data=%0h cnt=%0d",
                   mem_wr_addr, mem_wr_data, words_loaded, e.addr, e.data, e.cnt);
        end else begin
          $display("write addr=%0h data=%0h words_loaded=%0d", mem_wr_addr, mem_wr_data, words_loaded);
        end
      end
    end
    prev_wr = (mem_wr_en === 1'b1);
    if (done === 1'b1 && err === 1'b1) begin
      total++;
      bad++;
      $display("FAIL done_err_exclusive: both high at %0t", $time);
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int g;
    g = gaps ? $urandom_range(0, 2) : 0;
    for (int i = 0; i < g; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_byte  = 8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    check("in_ready_active", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Optionally presents a byte on the same edge that reset is sampled.
  task automatic do_reset(input bit with_byte, input logic [7:0] b);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = with_byte;
    in_byte  = b;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_in_ready",     {63'd0, in_ready},  64'd0);
    check("rst_wr_en",        {63'd0, mem_wr_en}, 64'd0);
    check("rst_core_rst",     {63'd0, core_rst},  64'd1);
    check("rst_done",         {63'd0, done},      64'd0);
    check("rst_err",          {63'd0, err},       64'd0);
    check("rst_words_loaded", {32'd0, words_loaded}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_rst_core_rst", {63'd0, core_rst}, 64'd1);
    check("post_rst_words",    {32'd0, words_loaded}, 64'd0);
    $display("reset applied");
  endtask

  task automatic send_header(input logic [31:0] n, input bit gaps);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gaps);
  endtask

  // Sends n words (or only 'stop_at' data bytes if stop_at < 4n), queueing the writes the model expects.
  task automatic send_data(input logic [7:0] d[], input int n, input int stop_at, input bit gaps,
                           output logic [7:0] csum);
    csum = 8'h00;
    for (int k = 0; k < n; k++) begin
      if (4*k + 4 <= stop_at) begin
        wr_t e;
        e.addr = BASE + 64'(4*k);
        e.data = {d[4*k+3], d[4*k+2], d[4*k+1], d[4*k]};
        e.cnt  = 32'(k + 1);
        exp_q.push_back(e);
      end
    end
    for (int i = 0; i < 4*n; i++) csum ^= d[i];
    for (int i = 0; i < stop_at; i++) send_byte(d[i], gaps);
  endtask

  task automatic check_final(input bit exp_done, input logic [31:0] exp_words, input string tag);
    @(negedge clk);
    check({tag, "_done"},     {63'd0, done},     {63'd0, exp_done});
    check({tag, "_err"},      {63'd0, err},      {63'd0, !exp_done});
    check({tag, "_core_rst"}, {63'd0, core_rst}, {63'd0, !exp_done});
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_words"},    {32'd0, words_loaded}, {32'd0, exp_words});
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'($urandom);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check({tag, "_absorb"}, {62'd0, done, err}, {62'd0, exp_done, !exp_done});
    $display("load %s finished done=%0b err=%0b words_loaded=%0d", tag, done, err, words_loaded);
  endtask

  task automatic full_load(input int n, input bit corrupt, input bit gaps, input string tag);
    logic [7:0] d[];
    logic [7:0] cs;
    d = new[4*n];
    foreach (d[i]) d[i] = 8'($urandom);
    send_header(32'(n), gaps);
    send_data(d, n, 4*n, gaps, cs);
    send_byte(corrupt ? (cs ^ 8'(1 + $urandom_range(0, 254))) : cs, gaps);
    check_final(!corrupt, 32'(n), tag);
  endtask

  task automatic bad_header(input logic [31:0] n, input string tag);
    send_header(n, 1'b0);
    @(negedge clk);
    check({tag, "_err"},      {63'd0, err},      64'd1);
    check({tag, "_done"},     {63'd0, done},     64'd0);
    check({tag, "_in_ready"}, {63'd0, in_ready}, 64'd0);
    check({tag, "_words"},    {32'd0, words_loaded}, 64'd0);
    $display("header %0h rejected err=%0b", n, err);
  endtask

  initial begin
    logic [7:0] d[];
    logic [7:0] cs;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;

    // Directed N=1 load with good checksum.
    do_reset(1'b0, 8'h00);
    d = new[4];
    d[0] = 8'h78; d[1] = 8'h56; d[2] = 8'h34; d[3] = 8'h12;
    send_header(32'd1, 1'b0);
    send_data(d, 1, 4, 1'b0, cs);
    check("n1_csum_model", {56'd0, cs}, 64'h08);
    send_byte(8'h08, 1'b0);
    check_final(1'b1, 32'd1, "n1_good");

    // Same stream, wrong checksum.
    do_reset(1'b0, 8'h00);
    send_header(32'd1, 1'b0);
    send_data(d, 1, 4, 1'b0, cs);
    send_byte(8'h09, 1'b0);
    check_final(1'b0, 32'd1, "n1_bad");

    // Empty program.
    do_reset(1'b0, 8'h00);
    send_header(32'd0, 1'b0);
    send_byte(8'h00, 1'b0);
    check_final(1'b1, 32'd0, "n0");

    // Oversized word counts.
    do_reset(1'b0, 8'h00);
    bad_header(MAXW + 32'd1, "too_big");
    do_reset(1'b0, 8'h00);
    bad_header(32'hFFFF_FFFF, "all_ones");

    // N=2 with random gaps.
    do_reset(1'b0, 8'h00);
    full_load(2, 1'b0, 1'b1, "n2_gaps");

    // Reset after 6 data bytes of an N=2 load, then a fresh load.
    do_reset(1'b0, 8'h00);
    d = new[8];
    foreach (d[i]) d[i] = 8'($urandom);
    send_header(32'd2, 1'b1);
    send_data(d, 2, 6, 1'b1, cs);
    do_reset(1'b0, 8'h00);
    full_load(2, 1'b0, 1'b1, "after_abort");

    // Reset on the same edge as the 4th byte of word 1: no strobe for that word.
    do_reset(1'b0, 8'h00);
    send_header(32'd2, 1'b0);
    send_data(d, 2, 7, 1'b0, cs);
    do_reset(1'b1, d[7]);
    full_load(1, 1'b0, 1'b0, "after_edge_rst");

    // Randomized loads.
    for (int t = 0; t < 12; t++) begin
      do_reset(1'b0, 8'h00);
      full_load($urandom_range(0, 6), ($urandom_range(0, 3) == 0), 1'b1, $sformatf("rand%0d", t));
    end

    repeat (3) @(negedge clk);
    check("pending_writes", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
